// File: rtl/ap_pkg.sv
// Shared encodings for the associative-processor tag unit: tag ops, FSM states
// and the default row geometry.
package ap_pkg;
  localparam int ROWS_DFLT     = 8;
  localparam int ROW_ADDR_BITS = $clog2(ROWS_DFLT);

  typedef enum logic [1:0] {
    TAG_LOAD  = 2'd0,
    TAG_AND   = 2'd1,
    TAG_OR    = 2'd2,
    TAG_CLEAR = 2'd3
  } tag_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;
endpackage

// File: rtl/ap_tag_unit_if.sv
// Bus between the CAM array / scan consumer and the tag unit.
// The master side drives compares, writes and the scan handshake; the slave is the tag unit.
interface ap_tag_unit_if #(
  parameter int ROWS          = ap_pkg::ROWS_DFLT,
  parameter int ROW_ADDR_BITS = ap_pkg::ROW_ADDR_BITS
);
  import ap_pkg::*;

  logic [ROWS-1:0]          match;
  logic                     cmp_valid;
  tag_op_e                  tag_op;
  logic                     wr_en;
  logic [ROWS-1:0]          row_we;
  logic                     any_match;
  logic [ROW_ADDR_BITS:0]   tag_count;
  logic                     scan_start;
  logic                     scan_abort;
  logic                     out_valid;
  logic                     out_ready;
  logic [ROW_ADDR_BITS-1:0] out_addr;
  logic                     out_last;
  logic                     scan_done;
  logic                     busy;
  logic                     err;

  modport slave (
    input  match, cmp_valid, tag_op, wr_en, scan_start, scan_abort, out_ready,
    output row_we, any_match, tag_count, out_valid, out_addr, out_last, scan_done, busy, err
  );

  modport master (
    output match, cmp_valid, tag_op, wr_en, scan_start, scan_abort, out_ready,
    input  row_we, any_match, tag_count, out_valid, out_addr, out_last, scan_done, busy, err
  );
endinterface

// File: rtl/ap_prio_enc.sv
// Lowest-set-bit priority encoder with a found flag and an exactly-one-bit flag.
module ap_prio_enc #(
  parameter int ROWS          = 8,
  parameter int ROW_ADDR_BITS = $clog2(ROWS)
) (
  input  logic [ROWS-1:0]          vec,
  output logic [ROW_ADDR_BITS-1:0] idx,
  output logic                     found,
  output logic                     single
);
  // Walk from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = ROWS - 1; i >= 0; i--)
      if (vec[i]) idx = i[ROW_ADDR_BITS-1:0];
  end

  assign found  = |vec;
  assign single = found && ((vec & (vec - ROWS'(1))) == '0);
endmodule

// File: rtl/ap_tag_unit.sv
// Tag register behind the CAM row array: combines compare passes, gates masked
// writes, and scans tagged rows lowest-first over a valid/ready handshake.
module ap_tag_unit #(
  parameter int ROWS          = ap_pkg::ROWS_DFLT,
  parameter int ROW_ADDR_BITS = $clog2(ROWS)
) (
  input logic           clka,
  input logic           rst,
  ap_tag_unit_if.slave  bus
);
  import ap_pkg::*;

  state_e                   state_q, state_d;
  logic [ROWS-1:0]          tags_q, tags_d;
  logic [ROWS-1:0]          pend_q, pend_d;
  logic                     err_q, err_d;
  logic                     done_q, done_d;
  logic [ROW_ADDR_BITS-1:0] low_idx;
  logic                     low_found, low_single;
  logic [ROW_ADDR_BITS:0]   pop;
  logic                     in_scan;

  ap_prio_enc #(.ROWS(ROWS), .ROW_ADDR_BITS(ROW_ADDR_BITS)) u_prio (
    .vec    (pend_q),
    .idx    (low_idx),
    .found  (low_found),
    .single (low_single)
  );

  assign in_scan = (state_q == ST_SCAN);

  always_ff @(posedge clka) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tags_q  <= '0;
      pend_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tags_q  <= tags_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tags_d  = tags_q;
    pend_d  = pend_q;
    err_d   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A compare wins over a same-cycle scan request; the scan is dropped and flagged.
        if (bus.cmp_valid) begin
          err_d = bus.scan_start;
          case (bus.tag_op)
            TAG_LOAD: tags_d = bus.match;
            TAG_AND:  tags_d = tags_q & bus.match;
            TAG_OR:   tags_d = tags_q | bus.match;
            default:  tags_d = '0;
          endcase
        end else if (bus.scan_start) begin
          if (tags_q == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_SCAN;
            pend_d  = tags_q;
          end
        end
      end
      default: begin
        err_d = bus.cmp_valid | bus.scan_start | bus.wr_en;
        if (bus.scan_abort) begin
          state_d = ST_IDLE;
          pend_d  = '0;
        end else if (bus.out_ready && low_found) begin
          pend_d[low_idx] = 1'b0;
          if (low_single) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
    endcase
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < ROWS; i++)
      pop = pop + {{ROW_ADDR_BITS{1'b0}}, tags_q[i]};
  end

  // Write enables are combinational so the array commits on the same edge as wr_en.
  assign bus.row_we    = (bus.wr_en && !in_scan) ? tags_q : '0;
  assign bus.any_match = |tags_q;
  assign bus.tag_count = pop;
  assign bus.out_valid = in_scan;
  assign bus.out_addr  = in_scan ? low_idx : '0;
  assign bus.out_last  = in_scan & low_single;
  assign bus.scan_done = done_q;
  assign bus.busy      = in_scan;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_ap_tag_unit.sv
// Bench for ap_tag_unit: directed scenarios with constant expectations, then
// randomized traffic checked against a queue-based reference model.
module tb_ap_tag_unit;
  import ap_pkg::*;

  localparam int ROWS = 8;
  localparam int AB   = 3;

  logic clka = 1'b0;
  logic rst  = 1'b1;
  int   nchecks = 0;
  int   nerr    = 0;

  always #5 clka = ~clka;

  ap_tag_unit_if #(.ROWS(ROWS), .ROW_ADDR_BITS(AB)) bus ();

  ap_tag_unit #(.ROWS(ROWS), .ROW_ADDR_BITS(AB)) dut (
    .clka (clka),
    .rst  (rst),
    .bus  (bus.slave)
  );

  // Reference model: tag value, scan flag and a queue of row indices still to emit.
  logic [7:0] m_tags = '0;
  bit         m_scan = 0;
  bit         m_err  = 0;
  bit         m_done = 0;
  int         m_q[$];

  task automatic model_edge();
    bit e_err, e_done;
    e_err = 0;
    e_done = 0;
    if (rst) begin
      m_tags = '0; m_scan = 0; m_q.delete(); m_err = 0; m_done = 0;
      return;
    end
    if (m_scan) begin
      e_err = bus.cmp_valid || bus.scan_start || bus.wr_en;
      if (bus.scan_abort) begin
        m_q.delete(); m_scan = 0;
      end else if (bus.out_ready) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) begin m_scan = 0; e_done = 1; end
      end
    end else if (bus.cmp_valid) begin
      e_err = bus.scan_start;
      case (bus.tag_op)
        TAG_LOAD: m_tags = bus.match;
        TAG_AND:  m_tags = m_tags & bus.match;
        TAG_OR:   m_tags = m_tags | bus.match;
        default:  m_tags = '0;
      endcase
    end else if (bus.scan_start) begin
      if (m_tags == 0) e_done = 1;
      else begin
        for (int i = 0; i < ROWS; i++) if (m_tags[i]) m_q.push_back(i);
        m_scan = 1;
      end
    end
    m_err = e_err;
    m_done = e_done;
  endtask

  function automatic logic [20:0] exp_vec();
    logic [7:0] rw;
    logic [2:0] a;
    bit         last;
    rw = (bus.wr_en && !m_scan) ? m_tags : 8'h00;
    a = 3'd0;
    last = 0;
    if (m_scan && m_q.size() > 0) begin
      a = 3'(m_q[0]);
      last = (m_q.size() == 1);
    end
    return {rw, m_tags != 0, 4'($countones(m_tags)), m_scan, a, last, m_done, m_scan, m_err};
  endfunction

  function automatic logic [20:0] dut_vec();
    return {bus.row_we, bus.any_match, bus.tag_count, bus.out_valid, bus.out_addr,
            bus.out_last, bus.scan_done, bus.busy, bus.err};
  endfunction

  task automatic set_in(bit cv, logic [1:0] op, logic [7:0] mt, bit wr, bit ss, bit sa, bit rdy);
    bus.cmp_valid  = cv;
    bus.tag_op     = tag_op_e'(op);
    bus.match      = mt;
    bus.wr_en      = wr;
    bus.scan_start = ss;
    bus.scan_abort = sa;
    bus.out_ready  = rdy;
  endtask

  task automatic tick();
    @(posedge clka);
    model_edge();
    @(negedge clka);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(0, 0, 8'h00, 0, 0, 0, 0);
    tick();
    for (int k = 0; k < 3; k++) begin
      set_in(1, 2'($urandom_range(0, 3)), 8'($urandom), 1, 1, 0, 1);
      #1;
      nchecks++;
      if (dut_vec() !== 21'h0) begin
        nerr++;
        $display("FAIL reset_outputs: got %h expected %h", dut_vec(), 21'h0);
      end
      tick();
    end
    rst = 1'b0;
    set_in(0, 0, 8'h00, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_tag_ops();
    set_in(1, TAG_LOAD, 8'hA4, 0, 0, 0, 0); tick();
    set_in(0, 0, 8'h00, 0, 0, 0, 0); #1;
    nchecks++;
    if ({bus.any_match, bus.tag_count} !== {1'b1, 4'd3}) begin
      nerr++;
      $display("FAIL load_a4: got any=%b cnt=%0d expected any=1 cnt=3", bus.any_match, bus.tag_count);
    end
    set_in(1, TAG_AND, 8'h0F, 0, 0, 0, 0); tick();
    set_in(0, 0, 8'h00, 1, 0, 0, 0); #1;
    nchecks++;
    if (bus.row_we !== 8'h04) begin
      nerr++;
      $display("FAIL and_0f: got row_we=%h expected 04", bus.row_we);
    end
    set_in(1, TAG_OR, 8'h81, 0, 0, 0, 0); tick();
    set_in(0, 0, 8'h00, 1, 0, 0, 0); #1;
    nchecks++;
    if ({bus.row_we, bus.tag_count} !== {8'h85, 4'd3}) begin
      nerr++;
      $display("FAIL or_81_row_we: got row_we=%h cnt=%0d expected 85 cnt=3", bus.row_we, bus.tag_count);
    end
    set_in(0, 0, 8'h00, 0, 0, 0, 0); #1;
    nchecks++;
    if (bus.row_we !== 8'h00) begin
      nerr++;
      $display("FAIL row_we_idle_off: got %h expected 00", bus.row_we);
    end
    tick();
  endtask

  task automatic test_scan_full();
    logic [2:0] addrs [3];
    addrs = '{3'd0, 3'd2, 3'd7};
    set_in(0, 0, 8'h00, 0, 1, 0, 1); tick();
    for (int k = 0; k < 3; k++) begin
      set_in(0, 0, 8'h00, 0, 0, 0, 1); #1;
      nchecks++;
      if ({bus.out_valid, bus.out_addr, bus.out_last} !== {1'b1, addrs[k], k == 2}) begin
        nerr++;
        $display("FAIL scan_full[%0d]: got v=%b a=%0d l=%b expected v=1 a=%0d l=%b",
                 k, bus.out_valid, bus.out_addr, bus.out_last, addrs[k], k == 2);
      end
      tick();
    end
    set_in(0, 0, 8'h00, 0, 0, 0, 0); #1;
    nchecks++;
    if ({bus.scan_done, bus.busy, bus.out_valid, bus.tag_count} !== {3'b100, 4'd3}) begin
      nerr++;
      $display("FAIL scan_full_done: got done=%b busy=%b v=%b cnt=%0d expected 1 0 0 3",
               bus.scan_done, bus.busy, bus.out_valid, bus.tag_count);
    end
    tick(); #1;
    nchecks++;
    if (bus.scan_done !== 1'b0) begin
      nerr++;
      $display("FAIL scan_done_pulse: got %b expected 0", bus.scan_done);
    end
  endtask

  task automatic test_scan_stall();
    logic [2:0] addrs [3];
    addrs = '{3'd0, 3'd2, 3'd7};
    set_in(0, 0, 8'h00, 0, 1, 0, 0); tick();
    for (int k = 0; k < 3; k++) begin
      set_in(0, 0, 8'h00, 0, 0, 0, 0); #1;
      nchecks++;
      if ({bus.out_valid, bus.out_addr, bus.out_last} !== {1'b1, 3'd0, 1'b0}) begin
        nerr++;
        $display("FAIL stall_hold[%0d]: got v=%b a=%0d l=%b expected v=1 a=0 l=0",
                 k, bus.out_valid, bus.out_addr, bus.out_last);
      end
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      set_in(0, 0, 8'h00, 0, 0, 0, 1); #1;
      nchecks++;
      if ({bus.out_valid, bus.out_addr} !== {1'b1, addrs[k]}) begin
        nerr++;
        $display("FAIL stall_release[%0d]: got v=%b a=%0d expected v=1 a=%0d",
                 k, bus.out_valid, bus.out_addr, addrs[k]);
      end
      tick();
    end
    set_in(0, 0, 8'h00, 0, 0, 0, 0); #1;
    nchecks++;
    if ({bus.scan_done, bus.busy} !== 2'b10) begin
      nerr++;
      $display("FAIL stall_done: got done=%b busy=%b expected 1 0", bus.scan_done, bus.busy);
    end
    tick();
  endtask

  task automatic test_clear_scan();
    set_in(1, TAG_CLEAR, 8'hFF, 0, 0, 0, 0); tick();
    set_in(0, 0, 8'h00, 0, 1, 0, 1); #1;
    nchecks++;
    if ({bus.any_match, bus.tag_count} !== 5'b0) begin
      nerr++;
      $display("FAIL clear_tags: got any=%b cnt=%0d expected 0 0", bus.any_match, bus.tag_count);
    end
    tick();
    set_in(0, 0, 8'h00, 0, 0, 0, 1); #1;
    nchecks++;
    if ({bus.scan_done, bus.out_valid, bus.busy} !== 3'b100) begin
      nerr++;
      $display("FAIL empty_scan: got done=%b v=%b busy=%b expected 1 0 0",
               bus.scan_done, bus.out_valid, bus.busy);
    end
    tick();
  endtask

  task automatic test_conflicts();
    set_in(1, TAG_LOAD, 8'h85, 0, 0, 0, 0); tick();
    set_in(0, 0, 8'h00, 0, 1, 0, 0); tick();
    set_in(1, TAG_LOAD, 8'hFF, 1, 0, 0, 0); #1;
    nchecks++;
    if (bus.row_we !== 8'h00) begin
      nerr++;
      $display("FAIL scan_row_we_blocked: got %h expected 00", bus.row_we);
    end
    tick();
    set_in(0, 0, 8'h00, 0, 0, 0, 1); #1;
    nchecks++;
    if ({bus.err, bus.tag_count, bus.out_addr} !== {1'b1, 4'd3, 3'd0}) begin
      nerr++;
      $display("FAIL scan_cmp_reject: got err=%b cnt=%0d a=%0d expected 1 3 0",
               bus.err, bus.tag_count, bus.out_addr);
    end
    tick();
    set_in(0, 0, 8'h00, 0, 0, 1, 1); #1;
    nchecks++;
    if ({bus.out_addr, bus.err} !== {3'd2, 1'b0}) begin
      nerr++;
      $display("FAIL abort_addr: got a=%0d err=%b expected 2 0", bus.out_addr, bus.err);
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      set_in(0, 0, 8'h00, 0, 0, 0, 0); #1;
      nchecks++;
      if ({bus.busy, bus.out_valid, bus.scan_done} !== 3'b000) begin
        nerr++;
        $display("FAIL abort_idle[%0d]: got busy=%b v=%b done=%b expected 0 0 0",
                 k, bus.busy, bus.out_valid, bus.scan_done);
      end
      tick();
    end
    set_in(1, TAG_OR, 8'h02, 0, 1, 0, 0); tick();
    set_in(0, 0, 8'h00, 0, 0, 0, 0); #1;
    nchecks++;
    if ({bus.err, bus.busy, bus.tag_count} !== {2'b10, 4'd4}) begin
      nerr++;
      $display("FAIL idle_cmp_and_start: got err=%b busy=%b cnt=%0d expected 1 0 4",
               bus.err, bus.busy, bus.tag_count);
    end
    tick();
  endtask

  task automatic test_rst_mid();
    set_in(1, TAG_LOAD, 8'h85, 0, 0, 0, 0); tick();
    set_in(0, 0, 8'h00, 0, 1, 0, 1); tick();
    set_in(0, 0, 8'h00, 0, 0, 0, 1); tick();
    rst = 1'b1;
    set_in(0, 0, 8'h00, 0, 0, 0, 1); tick();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      set_in(0, 0, 8'h00, 1, 0, 0, 1); #1;
      nchecks++;
      if (dut_vec() !== 21'h0) begin
        nerr++;
        $display("FAIL rst_mid_scan[%0d]: got %h expected 0", k, dut_vec());
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      set_in($urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)), 8'($urandom),
             $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
             $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1);
      #1;
      nchecks++;
      if (dut_vec() !== exp_vec()) begin
        nerr++;
        $display("FAIL random[%0d]: got %h expected %h", c, dut_vec(), exp_vec());
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    set_in(0, 0, 8'h00, 0, 0, 0, 0);
    @(negedge clka);
    test_reset();
    test_tag_ops();
    test_scan_full();
    test_scan_stall();
    test_clear_scan();
    test_conflicts();
    test_rst_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end
endmodule

// File: doc/ap_tag_unit.md
Name: ap_tag_unit

Overview:
- Downstream stage of the CAM row array in the associative processor.
- Captures the per-row match vector produced by the CAM cells into a tag register, and combines successive compare passes with LOAD/AND/OR/CLEAR.
- Drives per-row write enables back to the array for the masked-write phase.
- Provides a handshaked scan that walks the tagged rows in ascending address order.

Parameters:
- ROWS, 8, number of CAM rows (one match bit per row).
- ROW_ADDR_BITS, 3, row index width; must equal clog2(ROWS).

Ports:
- clka  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- match  in  ROWS  per-row match bits from the CAM array, sampled only when cmp_valid=1.
- cmp_valid  in  1  apply tag_op to match this cycle.
- tag_op  in  2  0=LOAD, 1=AND, 2=OR, 3=CLEAR.
- wr_en  in  1  request a masked write on all tagged rows.
- row_we  out  ROWS  per-row write enable to the array.
- any_match  out  1  OR-reduction of tags.
- tag_count  out  ROW_ADDR_BITS+1  popcount of tags.
- scan_start  in  1  begin a scan of the current tags.
- scan_abort  in  1  terminate the scan in progress.
- out_valid  out  1  out_addr is valid.
- out_ready  in  1  consumer accepts out_addr.
- out_addr  out  ROW_ADDR_BITS  index of the lowest pending tagged row.
- out_last  out  1  out_addr is the final pending row.
- scan_done  out  1  one-cycle pulse at scan completion.
- busy  out  1  state is SCAN.
- err  out  1  one-cycle pulse when a request is rejected.

Behaviour:
- Reset:
  - tags=0, pending=0, state=IDLE.
  - All outputs 0: row_we, any_match, tag_count, out_valid, out_addr, out_last, scan_done, busy, err.
  - rst mid-scan aborts immediately with no scan_done pulse.
- Tag update, IDLE only, applied on the edge after cmp_valid:
  - LOAD: tags<=match.
  - AND: tags<=tags&match.
  - OR: tags<=tags|match.
  - CLEAR: tags<=0; match is ignored.
- row_we: combinational, equals tags when wr_en=1 and state=IDLE, else 0. Zero latency, so the array writes on the same edge.
- any_match and tag_count: combinational from the tags register, valid the cycle after the update.
- States: IDLE, SCAN.
- IDLE -> SCAN on scan_start when tags!=0:
  - pending<=tags; tags itself is not modified by scanning.
  - out_valid rises the next cycle.
- scan_start with tags==0: stay in IDLE, scan_done pulses the next cycle, out_valid never rises.
- In SCAN:
  - out_valid=1.
  - out_addr = index of the lowest set bit of pending.
  - out_last = 1 when pending has exactly one bit set.
  - out_addr/out_last stay stable while out_ready=0.
- Handshake: on out_valid&out_ready, clear that bit of pending.
  - If out_last was 1: go to IDLE, out_valid=0 and scan_done=1 the next cycle.
  - Otherwise: the next address is presented the next cycle, giving 1 address/cycle at full throughput.
- scan_abort in SCAN: next cycle IDLE, pending=0, no scan_done; it has priority over a same-cycle handshake.
- Conflicts, each rejected with err pulsed the next cycle:
  - cmp_valid, scan_start or wr_en while in SCAN: ignored (row_we forced 0).
  - cmp_valid and scan_start together in IDLE: the tag update is applied and scan_start is dropped.
- Width rules: tag_count is wide enough for ROWS (count 8 needs 4 bits). out_addr is a zero-extended index.

Decomposition:
- Shared package ap_pkg holds:
  - tag_op encodings TAG_LOAD/TAG_AND/TAG_OR/TAG_CLEAR.
  - state encoding ST_IDLE/ST_SCAN.
  - helper width constant ROW_ADDR_BITS.
- One combinational sub-module, ap_prio_enc (ROWS in -> lowest index, found, single-bit flag), used for out_addr/out_last.
- Popcount stays inline.

Test Plan:
- Reset, then cmp_valid LOAD with match=8'hA4 -> next cycle any_match=1, tag_count=3; all outputs were 0 during reset.
- AND with 8'h0F -> tags=8'h04; then OR with 8'h81 -> tags=8'h85. wr_en=1 in IDLE -> row_we=8'h85 in the same cycle.
- Tags 8'h85, scan_start, out_ready held 1:
  - out_addr=0,2,7 on consecutive cycles, out_last only with 7.
  - scan_done pulses the cycle after 7, busy is 0 again.
  - tag_count is still 3.
- Tags 8'h85, scan_start, out_ready=0 for 3 cycles -> out_addr=0 and out_valid=1 held stable. Then out_ready=1 -> 2, 7 follow.
- CLEAR, then scan_start -> out_valid stays 0, scan_done pulses the next cycle.
- During a scan of 8'h85:
  - cmp_valid LOAD 8'hFF -> err pulse, tags unchanged.
  - scan_abort after the first address -> IDLE, no scan_done.
  - New scan, then rst after the first address -> all outputs 0 and tags=0 the next cycle.
